microwave_ctrl_n: RTL
=====================

Name: microwave_ctrl_n

Overview:
Parametrised successor to the single-shot microwave controller. It provides an N-digit BCD MM..:SS timer with an integrated keypad debouncer, seconds normalisation on start and a pause/resume FSM. Each digit has a 7-segment output.
It sits between the front-panel inputs (keypad, start/stop/clear, door switch) and the magnetron driver/display. One clock domain.

Parameters:
NDIGITS, 4, number of BCD digits; the lowest two are seconds, the rest are minutes (legal range 3..6)
TICKS_PER_SEC, 50, clock cycles per one-second decrement
DEBOUNCE_CYCLES, 2, cycles a keypad code must be stable before it is accepted (2 cycles = 40 ms at 50 Hz)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
keypad  in  10  one-hot key 0..9; bit k = digit k
startn  in  1  start/resume, active low
stopn  in  1  pause, active low
clearn  in  1  clear time, active low
door_closed  in  1  1 = door closed
digits  out  4*NDIGITS  BCD time; digit 0 is the LSB nibble (seconds ones)
segs  out  7*NDIGITS  segments gfedcba per digit, active high
mag_on  out  1  magnetron enable
state  out  2  FSM state encoding
done  out  1  one-cycle pulse when the count reaches zero
beep  out  1  done alarm (see Optional Feature)

Behaviour:
- Clocking and reset
  - One clock; resetn is synchronous and active-low.
  - Reset values: digits=0, mag_on=0, state=IDLE, done=0, beep=0, prescaler=0, debouncer idle.
- FSM states: IDLE(0), COOK(1), PAUSED(2), DONE(3). mag_on=1 only in COOK (registered, same cycle as state).
- Button edge detection: startn, stopn and clearn are edge-detected internally (registered previous value). A "press" is a sample of 0 where the previous sample was 1. Holding a button acts once.
- Keypad debounce
  - An input code is a candidate only if it has exactly one bit set; zero-bit and multi-bit codes are not candidates.
  - A candidate is accepted after it is stable for DEBOUNCE_CYCLES consecutive cycles.
  - After acceptance, the next key is armed only once keypad has been all-zero for DEBOUNCE_CYCLES cycles. Holding a key for any duration enters exactly one digit; glitches shorter than DEBOUNCE_CYCLES are ignored.
- Digit entry
  - An accepted key in IDLE, PAUSED or DONE shifts digits left one nibble and inserts the key as digit 0; the top digit is discarded. DONE goes to IDLE.
  - Keys accepted during COOK are discarded.
- Start press: effective in IDLE/PAUSED/DONE only when door_closed=1 and digits!=0. Otherwise it is ignored and the state is unchanged.
- Normalisation (same cycle as start): if the seconds value is 60..99, seconds -= 60 and minutes += 1.
  - If minutes overflow, the time saturates to all-9 minutes and 59 seconds.
  - Example: 3:92 -> 4:32.
- Counting in COOK
  - The prescaler counts 0..TICKS_PER_SEC-1; on wrap the time decrements by one second.
  - Decrement borrow rules: seconds x0 -> (x-1)9; 00 -> 59 with a minute borrow; minute digits borrow as BCD.
  - The prescaler clears on every entry to COOK.
- Reaching zero: on the decrement that produces all-zero, go to DONE, mag_on=0, and pulse done for one cycle.
- Pause: stopn press or door_closed=0 during COOK goes to PAUSED. The time and prescaler value are held. Resume requires a new start press with the door closed.
- Clear: a clearn press in any state zeroes digits and goes to IDLE (mag_on=0 next cycle). It does not pulse done.
- Priority per cycle: resetn > clear > door-open/stop > start > key > tick.
- segs is a combinational decode of digits. Codes 0-9 are standard. Values 10-15 (unreachable) display blank.

Optional Feature:
MW_DONE_BEEP_EN
- Defined: beep goes high on entry to DONE for 3*TICKS_PER_SEC cycles. Any press, key, or clear drops it early.
- Undefined: beep is tied 0 and no alarm counter is synthesised.

Decomposition:
- Package mw_pkg holds:
  - the state typedef/localparams (IDLE, COOK, PAUSED, DONE)
  - the bcd_to_7seg function
  - the one-hot-to-BCD encode function
  - the KEY_NONE constant
- Sub-module mw_keypad_debounce(DEBOUNCE_CYCLES) takes clock, resetn and keypad, and outputs key_valid (1-cycle pulse) and key_val[3:0].

Test Plan:
1. Keys 4,4,7 (each 1 s), then a start press; open the door after 1 s, close it, press start -> 4:47 then COOK; in PAUSED, mag_on=0 and digits frozen; resumes and counts to 0:00, done pulses once, state=DONE.
2. Door open, keys 3,9,2, start press -> start ignored, state IDLE, digits 0392; close the door and start -> digits 0432 COOK; stop after 30 s -> 0402 frozen; restart -> counts to zero.
3. Key 5 pressed, bounced low 20 ms then high again after 2,2 -> only one 5 entered, digits 0225.
4. Key 1, key 5 held 30 s, key 6 -> digits 0156 exactly.
5. Keys 2,5,0, clear -> digits 0000, state IDLE; keys 1,5,0, start, clear 2 s later -> digits 0000, mag_on=0, no done pulse.
6. Keys 2,0,5, start, then keys 3,5,0 while cooking -> digits unchanged apart from the countdown; start with digits 0000 -> stays IDLE.

Source files
------------

// File: rtl/mw_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mw_pkg
//  Purpose  : Shared states, constants and decode helpers for microwave_ctrl_n.
//  Revision : 1.0  initial release
// ============================================================================
package mw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } mw_state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;

    // Segment order gfedcba, active high; non-decimal codes are blank.
    function automatic logic [6:0] bcd_to_7seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] onehot);
        logic [3:0] val;
        val = KEY_NONE;
        for (int k = 0; k < 10; k++) begin
            if (onehot[k]) val = 4'(k);
        end
        return val;
    endfunction

    function automatic logic is_onehot10(input logic [9:0] code);
        return (code != 10'd0) && ((code & (code - 10'd1)) == 10'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mw_keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : mw_keypad_debounce
//  Purpose  : Accepts a one-hot key once it is stable; re-arms after release.
//  Revision : 1.0  initial release
// ============================================================================
module mw_keypad_debounce
    import mw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] keypad,
    output logic       key_valid,
    output logic [3:0] key_val
);

    localparam int RUN_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE_CYCLES);

    logic [9:0]       r_last;
    logic [RUN_W-1:0] r_run;
    logic             r_armed;
    logic [RUN_W-1:0] w_run_next;
    logic             w_stable;

    // r_run is the length of the current run of identical samples, saturating.
    always_comb begin
        if (keypad != r_last) begin
            w_run_next = RUN_W'(1);
        end else if (r_run == RUN_MAX) begin
            w_run_next = r_run;
        end else begin
            w_run_next = r_run + RUN_W'(1);
        end
        w_stable = (w_run_next == RUN_MAX);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_last    <= 10'd0;
            r_run     <= '0;
            r_armed   <= 1'b1;
            key_valid <= 1'b0;
            key_val   <= KEY_NONE;
        end else begin
            r_last    <= keypad;
            r_run     <= w_run_next;
            key_valid <= 1'b0;
            if (r_armed) begin
                if (is_onehot10(keypad) && w_stable) begin
                    key_valid <= 1'b1;
                    key_val   <= onehot_to_bcd(keypad);
                    r_armed   <= 1'b0;
                end
            end else if ((keypad == 10'd0) && w_stable) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/microwave_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_ctrl_n
//  Purpose  : N-digit BCD MM..:SS cook timer with keypad entry, pause/resume.
//             Optional done alarm enabled by defining MW_DONE_BEEP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module microwave_ctrl_n
    import mw_pkg::*;
#(
    parameter int NDIGITS         = 4,
    parameter int TICKS_PER_SEC   = 50,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [9:0]             keypad,
    input  logic                   startn,
    input  logic                   stopn,
    input  logic                   clearn,
    input  logic                   door_closed,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [7*NDIGITS-1:0]   segs,
    output logic                   mag_on,
    output logic [1:0]             state,
    output logic                   done,
    output logic                   beep
);

    localparam int NMIN    = NDIGITS - 2;
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    mw_state_t              r_state;
    logic [PRESC_W-1:0]     r_presc;
    logic                   r_startn_q;
    logic                   r_stopn_q;
    logic                   r_clearn_q;
    logic                   w_start_p;
    logic                   w_stop_p;
    logic                   w_clear_p;
    logic                   w_tick;
    logic                   w_key_valid;
    logic [3:0]             w_key_val;
    logic [4*NDIGITS-1:0]   w_dec;
    logic                   w_dec_zero;
    logic                   w_borrow;
    logic [4*NDIGITS-1:0]   w_norm;
    logic                   w_carry;
    logic [4*NDIGITS-1:0]   w_shift;

    mw_keypad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock     (clock),
        .resetn    (resetn),
        .keypad    (keypad),
        .key_valid (w_key_valid),
        .key_val   (w_key_val)
    );

    assign w_start_p = r_startn_q & ~startn;
    assign w_stop_p  = r_stopn_q  & ~stopn;
    assign w_clear_p = r_clearn_q & ~clearn;
    assign w_tick    = (r_presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign w_shift   = {digits[4*NDIGITS-5:0], w_key_val};

    // One-second decrement; the seconds tens digit wraps to 5, all others to 9.
    always_comb begin
        w_dec    = digits;
        w_borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w_borrow) begin
                if (digits[4*i +: 4] != 4'd0) begin
                    w_dec[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end else begin
                    w_dec[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end
            end
        end
        w_dec_zero = (w_dec == '0);
    end

    // Seconds 60..99 fold into one extra minute; minute overflow saturates.
    always_comb begin
        w_norm  = digits;
        w_carry = 1'b0;
        if (digits[7:4] >= 4'd6) begin
            w_norm[7:4] = digits[7:4] - 4'd6;
            w_carry     = 1'b1;
            for (int i = 2; i < NDIGITS; i++) begin
                if (w_carry) begin
                    if (digits[4*i +: 4] == 4'd9) begin
                        w_norm[4*i +: 4] = 4'd0;
                    end else begin
                        w_norm[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
            if (w_carry) w_norm = {{NMIN{4'd9}}, 4'd5, 4'd9};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= IDLE;
            digits     <= '0;
            r_presc    <= '0;
            mag_on     <= 1'b0;
            done       <= 1'b0;
            r_startn_q <= 1'b1;
            r_stopn_q  <= 1'b1;
            r_clearn_q <= 1'b1;
        end else begin
            r_startn_q <= startn;
            r_stopn_q  <= stopn;
            r_clearn_q <= clearn;
            done       <= 1'b0;
            if (w_clear_p) begin
                digits  <= '0;
                r_state <= IDLE;
                mag_on  <= 1'b0;
            end else if ((r_state == COOK) && (!door_closed || w_stop_p)) begin
                r_state <= PAUSED;
                mag_on  <= 1'b0;
            end else if ((r_state != COOK) && w_start_p && door_closed && (digits != '0)) begin
                digits  <= w_norm;
                r_presc <= '0;
                r_state <= COOK;
                mag_on  <= 1'b1;
            end else if ((r_state != COOK) && w_key_valid) begin
                digits <= w_shift;
                if (r_state == DONE) r_state <= IDLE;
            end else if (r_state == COOK) begin
                if (w_tick) begin
                    r_presc <= '0;
                    digits  <= w_dec;
                    if (w_dec_zero) begin
                        r_state <= DONE;
                        mag_on  <= 1'b0;
                        done    <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end
        end
    end

    assign state = r_state;

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_seg
            assign segs[7*gi +: 7] = bcd_to_7seg(digits[4*gi +: 4]);
        end
    endgenerate

`ifdef MW_DONE_BEEP_EN
    localparam int BEEP_LEN = 3 * TICKS_PER_SEC;
    localparam int BEEP_W   = $clog2(BEEP_LEN);

    logic [BEEP_W-1:0] r_beep_cnt;
    logic              w_to_done;

    // Mirrors the FSM path that enters DONE from a final tick.
    assign w_to_done = (r_state == COOK) && !w_clear_p && door_closed && !w_stop_p &&
                       w_tick && w_dec_zero;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            beep       <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_to_done) begin
            beep       <= 1'b1;
            r_beep_cnt <= '0;
        end else if (beep) begin
            if (w_start_p || w_stop_p || w_clear_p || w_key_valid ||
                (r_beep_cnt == BEEP_W'(BEEP_LEN - 1))) begin
                beep <= 1'b0;
            end
            r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
        end
    end
`else
    assign beep = 1'b0;
`endif

endmodule
`default_nettype wire
